// File: rtl/linear_sensor_emu.sv
// Sensor-side emulator of a linear image sensor: times the ST integration window
// on SENSOR_CLK, then plays out a deterministic pixel stream followed by an EOC pulse.
module linear_sensor_emu #(
  parameter int NPIX      = 1024,
  parameter int START_DLY = 48,
  parameter int EOC_LEN   = 1,
  parameter int DW        = 12
) (
  input  logic          FPGA_CLK,
  input  logic          FPGA_RST,
  input  logic          SENSOR_CLK,
  input  logic          ST,
  output logic          EOC,
  output logic          PIX_VALID,
  output logic [10:0]   PIX_IDX,
  output logic [DW-1:0] PIX_DATA,
  output logic [20:0]   INTEG_CNT,
  output logic [15:0]   FRAME_CNT,
  output logic          BUSY,
  output logic          ERR,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_INTEG, S_DELAY, S_READ, S_EOCS} state_t;

  localparam int DLY_W = $clog2(START_DLY + 1);
  localparam int E_W   = $clog2(EOC_LEN + 1);
  localparam logic [20:0] INTEG_MAX = '1;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q, st_meta_q, st_sync_q;
  logic sclk_rise, st_s;
  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      st_meta_q   <= 1'b0;
      st_sync_q   <= 1'b0;
    end else begin
      sclk_meta_q <= SENSOR_CLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      st_meta_q   <= ST;
      st_sync_q   <= st_meta_q;
    end
  end
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign st_s      = st_sync_q;

  state_t           state_q, state_d;
  logic [20:0]      integ_q, integ_d, integ_cnt_q, integ_cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [10:0]      pix_q, pix_d, pix_idx_q, pix_idx_d;
  logic [E_W-1:0]   e_q, e_d;
  logic [DW-1:0]    pix_data_q, pix_data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             st_last_q, st_last_d, eoc_q, eoc_d, pix_valid_q, pix_valid_d;
  logic             busy_q, busy_d, err_q, err_d;

  always_comb begin
    state_d     = state_q;
    integ_d     = integ_q;
    integ_cnt_d = integ_cnt_q;
    dly_d       = dly_q;
    pix_d       = pix_q;
    pix_idx_d   = pix_idx_q;
    e_d         = e_q;
    pix_data_d  = pix_data_q;
    frame_cnt_d = frame_cnt_q;
    st_last_d   = st_last_q;
    eoc_d       = eoc_q;
    pix_valid_d = 1'b0;
    err_d       = err_q;
    if (sclk_rise) begin
      st_last_d = st_s;
      case (state_q)
        S_IDLE: begin
          if (st_s) begin
            state_d = S_INTEG;
            integ_d = 21'd1;
          end
        end
        S_INTEG: begin
          if (st_s) begin
            if (integ_q != INTEG_MAX) integ_d = integ_q + 21'd1;
          end else begin
            integ_cnt_d = integ_q;
            dly_d       = DLY_W'(1);
            pix_d       = 11'd0;
            state_d     = (START_DLY == 1) ? S_READ : S_DELAY;
          end
        end
        S_DELAY: begin
          dly_d = dly_q + DLY_W'(1);
          if (dly_q == DLY_W'(START_DLY - 1)) begin
            state_d = S_READ;
            pix_d   = 11'd0;
          end
        end
        S_READ: begin
          pix_valid_d = 1'b1;
          pix_idx_d   = pix_q;
          pix_data_d  = DW'({frame_cnt_q[1:0], pix_q[9:0]});
          pix_d       = pix_q + 11'd1;
          if (pix_q == 11'(NPIX - 1)) begin
            state_d = S_EOCS;
            eoc_d   = 1'b1;
            e_d     = E_W'(1);
          end
        end
        S_EOCS: begin
          if (e_q == E_W'(EOC_LEN)) begin
            eoc_d       = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = S_IDLE;
          end else begin
            e_d = e_q + E_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      // A fresh ST pulse mid-frame is flagged but otherwise ignored.
      if (st_s && !st_last_q &&
          (state_q == S_DELAY || state_q == S_READ || state_q == S_EOCS))
        err_d = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      integ_q     <= '0;
      integ_cnt_q <= '0;
      dly_q       <= '0;
      pix_q       <= '0;
      pix_idx_q   <= '0;
      e_q         <= '0;
      pix_data_q  <= '0;
      frame_cnt_q <= '0;
      st_last_q   <= 1'b0;
      eoc_q       <= 1'b0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      integ_q     <= integ_d;
      integ_cnt_q <= integ_cnt_d;
      dly_q       <= dly_d;
      pix_q       <= pix_d;
      pix_idx_q   <= pix_idx_d;
      e_q         <= e_d;
      pix_data_q  <= pix_data_d;
      frame_cnt_q <= frame_cnt_d;
      st_last_q   <= st_last_d;
      eoc_q       <= eoc_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign EOC       = eoc_q;
  assign PIX_VALID = pix_valid_q;
  assign PIX_IDX   = pix_idx_q;
  assign PIX_DATA  = pix_data_q;
  assign INTEG_CNT = integ_cnt_q;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/linear_sensor_emu.md
Name: linear_sensor_emu

Overview:
- Synthesizable emulator of the linear image sensor; it is the sensor-side end of the SENSOR_CLK/ST/EOC interface.
- Receives SENSOR_CLK and ST from the FPGA-side sensor driver, measures the integration window, and plays out a deterministic pixel stream.
- Asserts EOC at end of readout, so the driver-side EOC edge detector and EOC counter can be looped back on-chip or in simulation without a physical sensor.
- Runs entirely in the FPGA_CLK domain; SENSOR_CLK and ST are treated as asynchronous inputs.

Parameters:
NPIX, 1024, pixels per frame (>=2)
START_DLY, 48, SENSOR_CLK rising edges from the ST-low sample to the first pixel (>=1)
EOC_LEN, 1, SENSOR_CLK periods EOC stays high (>=1)
DW, 12, PIX_DATA width (>=12)

Ports:
FPGA_CLK  in  1  system clock
FPGA_RST  in  1  asynchronous active-low reset
SENSOR_CLK  in  1  sensor clock from the driver; asynchronous, at most FPGA_CLK/4
ST  in  1  start/integration signal from the driver; asynchronous
EOC  out  1  end-of-conversion, registered
PIX_VALID  out  1  one-FPGA_CLK strobe per pixel
PIX_IDX  out  11  index of the current pixel, 0..NPIX-1
PIX_DATA  out  DW  pixel value
INTEG_CNT  out  21  integration length, in SENSOR_CLK rising edges, of the last frame
FRAME_CNT  out  16  frames completed, wraps at 65535->0
BUSY  out  1  high in any state except IDLE
ERR  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync release): every output and internal register is 0; state=IDLE.
- Input conditioning:
  - SENSOR_CLK and ST each pass through a 2-flop synchronizer.
  - sclk_rise is a single-cycle strobe, asserted when the synchronized SENSOR_CLK is 1 and its previous sample was 0.
  - sclk_rise therefore occurs 3 FPGA_CLK cycles after the SENSOR_CLK rising edge.
  - st_s is the synchronized ST value. It is sampled only on sclk_rise cycles.
  - All state changes below happen only on sclk_rise cycles.
- States and transitions:
  - IDLE: when st_s=1, go to INTEG with integ=1.
  - INTEG:
    - st_s=1: integ increments, saturating at 2^21-1.
    - st_s=0: INTEG_CNT<=integ, dly=1, go to DELAY. If START_DLY=1, go straight to READ instead.
  - DELAY: dly increments. When dly reaches START_DLY, go to READ with pix=0.
  - READ:
    - Each sclk_rise drives one pixel. In the following cycle PIX_VALID=1 for exactly one FPGA_CLK, PIX_IDX=pix, PIX_DATA=zero-extended {FRAME_CNT[1:0], pix[9:0]}.
    - pix then increments. After pixel NPIX-1 has been issued, go to EOCS with EOC<=1, e=1.
  - EOCS:
    - EOC stays high. On each sclk_rise, e increments.
    - When e=EOC_LEN at sclk_rise: EOC<=0, FRAME_CNT increments, go to IDLE.
    - The IDLE st_s check is not applied on this same edge.
- Output holding:
  - PIX_IDX and PIX_DATA hold their last values between strobes.
  - INTEG_CNT holds until the next INTEG exit.
  - BUSY = (state != IDLE), registered.
- Protocol errors:
  - An st_s 0->1 transition seen at sclk_rise while in DELAY, READ or EOCS sets ERR (sticky until reset).
  - The frame in progress continues unchanged. That ST pulse is ignored, and a new frame starts only when st_s=1 is sampled in IDLE.
- Boundaries:
  - ST still high when entering IDLE starts a new frame on the next sclk_rise.
  - SENSOR_CLK stopped: state freezes, outputs hold, no timeout.
  - Reset asserted mid-frame: immediate return to IDLE with all outputs 0. EOC must never glitch high during reset.
- EOC rising edge to FPGA_CLK: EOC is registered, so one clean rising edge per frame is presented to the driver's edge detector.

Test Plan:
- Reset: hold FPGA_RST=0 with SENSOR_CLK toggling and ST=1 -> all outputs 0, BUSY=0. After release with ST=1 -> BUSY=1 within 4 FPGA_CLK of the next SENSOR_CLK rise.
- Basic frame (NPIX=8, START_DLY=3, EOC_LEN=1, SENSOR_CLK period 16 FPGA_CLK, ST high for 5 rises):
  - INTEG_CNT=5.
  - First PIX_VALID on the 3rd rise after the ST-low sample; 8 strobes spaced 16 cycles apart, PIX_IDX 0..7, PIX_DATA 0..7.
  - EOC high for 16 cycles, then FRAME_CNT=1.
- Second frame with same parameters -> PIX_DATA=0x400..0x407, FRAME_CNT=2, exactly 2 EOC rising edges counted by the downstream EOC counter.
- ST pulsed high during READ -> ERR=1 and stays 1; pixel count and EOC timing unchanged; no new frame until ST is sampled high in IDLE.
- Reset asserted at pixel 4 -> EOC, PIX_VALID, BUSY and FRAME_CNT go to 0 asynchronously; after release the next frame starts with PIX_IDX=0.
- Loopback with the driver (DIV=8, MAX=40000, HIGH=6000, NPIX=1024) -> INTEG_CNT=6000 and one EOC per ST period.
